// File: rtl/tt_um_lucas_270608_if.sv
// Tiny Tapeout tile pin bundle for the accumulator ALU.
// The harness side (master) drives enable, operand and opcode/strobe.
// The tile side (slave) drives the accumulator, the flags and the output enables.
interface tt_um_lucas_270608_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_lucas_270608.sv
// 8-bit accumulator ALU tile.
// An exec strobe arrives on uio_in[3] and the opcode on uio_in[2:0].
// The operand B arrives on ui_in, and the accumulator A drives uo_out.
// The flags Z/C/N/BUSY drive uio_out[7:4].
// MUL is an 8-step shift-add sequence; every other opcode completes in one cycle.
module tt_um_lucas_270608 (
    input  logic                  clk,
    input  logic                  rst,
    tt_um_lucas_270608_if.slave   bus
);
    localparam int DATA_W = 8;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_ROL  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    state_t                  state;
    logic [2:0]              cnt;
    logic [DATA_W-1:0]       acc;
    logic [DATA_W-1:0]       mcand;
    logic [DATA_W-1:0]       mplier;
    logic [2*DATA_W-1:0]     prod;
    logic                    flag_z;
    logic                    flag_c;
    logic                    flag_n;
    logic                    busy;
    logic                    stb_q;

    logic [DATA_W-1:0]       operand;
    logic [2:0]              opcode;
    logic                    strobe;
    logic                    exec;

    logic [DATA_W:0]         sum;
    logic [2*DATA_W-1:0]     rot;
    logic [DATA_W-1:0]       alu_res;
    logic                    alu_carry;

    logic [2*DATA_W-1:0]     step_add;
    logic [2*DATA_W-1:0]     prod_next;

    logic                    unused_bits;

    assign operand = bus.ui_in;
    assign opcode  = bus.uio_in[2:0];
    assign strobe  = bus.uio_in[3];
    // Rising edge of the strobe only, gated by enable and dropped while a multiply runs.
    assign exec    = strobe & ~stb_q & bus.ena & ~busy;

    assign unused_bits = &{1'b0, bus.uio_in[7:4]};

    // Single-cycle ALU result and carry/borrow for the current opcode.
    always_comb begin
        sum       = {1'b0, acc} + {1'b0, operand};
        rot       = {acc, acc} << operand[2:0];
        alu_res   = acc;
        alu_carry = 1'b0;
        case (opcode)
            OP_LOAD: alu_res = operand;
            OP_ADD: begin
                alu_res   = sum[DATA_W-1:0];
                alu_carry = sum[DATA_W];
            end
            OP_SUB: begin
                alu_res   = acc - operand;
                alu_carry = (acc < operand);
            end
            OP_AND:  alu_res = acc & operand;
            OP_OR:   alu_res = acc | operand;
            OP_XOR:  alu_res = acc ^ operand;
            // The upper half of {A,A} << r is A rotated left by r.
            OP_ROL:  alu_res = rot[2*DATA_W-1:DATA_W];
            default: alu_res = acc;
        endcase
    end

    // One shift-add step: add the multiplicand weighted by the current multiplier bit.
    always_comb begin
        step_add  = mplier[cnt] ? ({{DATA_W{1'b0}}, mcand} << cnt) : '0;
        prod_next = prod + step_add;
    end

    // Control FSM, accumulator, flags and multiply datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_n <= 1'b0;
            busy   <= 1'b0;
            stb_q  <= 1'b0;
        end else begin
            stb_q <= strobe;
            case (state)
                ST_IDLE: begin
                    if (exec) begin
                        if (opcode == OP_MUL) begin
                            mcand  <= acc;
                            mplier <= operand;
                            prod   <= '0;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= ST_MUL;
                        end else begin
                            acc    <= alu_res;
                            flag_c <= alu_carry;
                            flag_z <= (alu_res == '0);
                            flag_n <= alu_res[DATA_W-1];
                        end
                    end
                end
                ST_MUL: begin
                    prod <= prod_next;
                    if (cnt == 3'd7) begin
                        // The last step writes the low byte; a nonzero high byte sets carry.
                        acc    <= prod_next[DATA_W-1:0];
                        flag_c <= |prod_next[2*DATA_W-1:DATA_W];
                        flag_z <= (prod_next[DATA_W-1:0] == '0);
                        flag_n <= prod_next[DATA_W-1];
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.uo_out  = acc;
    assign bus.uio_out = {busy, flag_n, flag_c, flag_z, 4'b0000};
    assign bus.uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_lucas_270608.sv
// Bench for the accumulator ALU tile.
// It combines a behavioural model with directed operations and literal expectations.
module tb_tt_um_lucas_270608;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tt_um_lucas_270608_if bus ();

    tt_um_lucas_270608 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Model state, kept as plain integers
    int m_a, m_c, m_z, m_n, m_busy, m_stb, m_prod;
    int b, s, r, op;
    bit exec;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the tile, evaluated at every rising edge
    always @(posedge clk) begin
        if (rst) begin
            m_a = 0; m_c = 0; m_z = 0; m_n = 0; m_busy = 0; m_stb = 0; m_prod = 0;
        end else begin
            exec = bus.uio_in[3] && (m_stb == 0) && bus.ena && (m_busy == 0);
            if (m_busy > 0) begin
                m_busy = m_busy - 1;
                if (m_busy == 0) begin
                    m_a = m_prod % 256;
                    m_c = (m_prod > 255) ? 1 : 0;
                    m_z = (m_a == 0) ? 1 : 0;
                    m_n = (m_a >= 128) ? 1 : 0;
                end
            end else if (exec) begin
                b  = int'(bus.ui_in);
                op = int'(bus.uio_in[2:0]);
                case (op)
                    0: begin m_a = b; m_c = 0; end
                    1: begin s = m_a + b; m_a = s % 256; m_c = (s > 255) ? 1 : 0; end
                    2: begin m_c = (m_a < b) ? 1 : 0; m_a = (m_a - b + 256) % 256; end
                    3: begin m_a = m_a & b; m_c = 0; end
                    4: begin m_a = m_a | b; m_c = 0; end
                    5: begin m_a = m_a ^ b; m_c = 0; end
                    6: begin r = b % 8; m_a = ((m_a << r) | (m_a >> (8 - r))) % 256; m_c = 0; end
                    default: begin m_prod = m_a * b; m_busy = 8; end
                endcase
                if (op != 7) begin
                    m_z = (m_a == 0) ? 1 : 0;
                    m_n = (m_a >= 128) ? 1 : 0;
                end
            end
            m_stb = bus.uio_in[3] ? 1 : 0;
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("acc", bus.uo_out, m_a[7:0]);
            check("busy", {7'b0, bus.uio_out[7]}, {7'b0, (m_busy > 0)});
            check("oe", bus.uio_oe, 8'hF0);
            check("uio_low", {4'b0, bus.uio_out[3:0]}, 8'h00);
            if (m_busy == 0)
                check("flags_nzc", {5'b0, bus.uio_out[6:4]}, {5'b0, m_n[0], m_c[0], m_z[0]});
        end
    end

    // One strobe pulse, then a low cycle so the next pulse is a fresh edge
    task automatic do_op(input logic [2:0] o, input logic [7:0] val);
        bus.ui_in  = val;
        bus.uio_in = {4'b0, 1'b1, o};
        @(negedge clk);
        bus.uio_in = {4'b0, 1'b0, o};
        @(negedge clk);
    endtask

    task automatic do_mul(input logic [7:0] val, output int busy_cycles);
        bus.ui_in  = val;
        bus.uio_in = {4'b0, 1'b1, 3'd7};
        @(negedge clk);
        bus.uio_in = {4'b0, 1'b0, 3'd7};
        busy_cycles = 0;
        while (bus.uio_out[7] === 1'b1 && busy_cycles < 20) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    int bc;

    initial begin
        rst        = 1'b1;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_uo_out", bus.uo_out, 8'h00);
        check("rst_uio_out", bus.uio_out, 8'h00);
        check("rst_uio_oe", bus.uio_oe, 8'hF0);
        chk_on = 1'b1;
        rst    = 1'b0;
        @(negedge clk);

        do_op(3'd0, 8'h7F);
        do_op(3'd1, 8'h01);
        check("add_7f_01", bus.uo_out, 8'h80);
        check("add_7f_01_flags", bus.uio_out, 8'h40);
        do_op(3'd1, 8'h80);
        check("add_80_80", bus.uo_out, 8'h00);
        check("add_80_80_flags", bus.uio_out, 8'h30);

        do_op(3'd0, 8'h05);
        do_op(3'd2, 8'h06);
        check("sub_05_06", bus.uo_out, 8'hFF);
        check("sub_05_06_flags", bus.uio_out, 8'h60);

        do_op(3'd0, 8'h81);
        do_op(3'd6, 8'h01);
        check("rol_81_1", bus.uo_out, 8'h03);
        check("rol_81_1_flags", bus.uio_out, 8'h00);

        do_op(3'd0, 8'hF0);
        do_op(3'd3, 8'h3C);
        check("and", bus.uo_out, 8'h30);
        do_op(3'd4, 8'h0F);
        check("or", bus.uo_out, 8'h3F);
        do_op(3'd5, 8'hFF);
        check("xor", bus.uo_out, 8'hC0);
        check("xor_flags", bus.uio_out, 8'h40);

        do_op(3'd0, 8'h0C);
        do_mul(8'h15, bc);
        check("mul_busy_cycles", bc[7:0], 8'd8);
        check("mul_0c_15", bus.uo_out, 8'hFC);
        check("mul_0c_15_flags", bus.uio_out, 8'h40);
        @(negedge clk);

        do_op(3'd0, 8'h10);
        do_mul(8'h20, bc);
        check("mul2_busy_cycles", bc[7:0], 8'd8);
        check("mul_10_20", bus.uo_out, 8'h00);
        check("mul_10_20_flags", bus.uio_out, 8'h30);
        @(negedge clk);

        // A strobe level held for several clocks executes exactly once
        do_op(3'd0, 8'h00);
        bus.ui_in  = 8'h01;
        bus.uio_in = {4'b0, 1'b1, 3'd1};
        repeat (5) @(negedge clk);
        bus.uio_in = {4'b0, 1'b0, 3'd1};
        @(negedge clk);
        check("held_strobe", bus.uo_out, 8'h01);

        bus.ena = 1'b0;
        do_op(3'd1, 8'h01);
        check("ena_low", bus.uo_out, 8'h01);
        bus.ena = 1'b1;

        // A strobe raised while busy is dropped
        do_op(3'd0, 8'h03);
        bus.ui_in  = 8'h05;
        bus.uio_in = {4'b0, 1'b1, 3'd7};
        @(negedge clk);
        bus.uio_in = {4'b0, 1'b0, 3'd7};
        @(negedge clk);
        bus.ui_in  = 8'h01;
        bus.uio_in = {4'b0, 1'b1, 3'd1};
        @(negedge clk);
        bus.uio_in = {4'b0, 1'b0, 3'd1};
        bc = 0;
        while (bus.uio_out[7] === 1'b1 && bc < 20) begin
            bc++;
            @(negedge clk);
        end
        check("busy_strobe_timeout", {7'b0, (bc < 20)}, 8'h01);
        check("busy_strobe_ignored", bus.uo_out, 8'h0F);
        @(negedge clk);

        // Reset partway through a multiply
        do_op(3'd0, 8'h0C);
        bus.ui_in  = 8'h15;
        bus.uio_in = {4'b0, 1'b1, 3'd7};
        @(negedge clk);
        bus.uio_in = {4'b0, 1'b0, 3'd7};
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_mul_uo", bus.uo_out, 8'h00);
        check("rst_mid_mul_uio", bus.uio_out, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        do_op(3'd0, 8'h33);
        check("load_after_rst", bus.uo_out, 8'h33);

        do_op(3'd0, 8'hFF);
        do_op(3'd1, 8'h02);
        check("add_wrap", bus.uo_out, 8'h01);
        check("add_wrap_flags", bus.uio_out, 8'h20);

        repeat (2) @(negedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
